// File: rtl/calc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : calc_control_fsm
//  Description : Multi-cycle sequencer for the 16-bit core. Decodes the IR
//                opcode and drives every ALU/memory/register-file select and
//                enable, resolving branches from the live ALU flags and
//                stretching fetch/load/store on the memory ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] input_opcode,
  input  logic [3:0] input_funct,
  input  logic       input_Zero,
  input  logic       input_negative,
  input  logic       input_mem_ready,
  output logic [1:0] output_ALUSrcA,
  output logic [1:0] output_ALUSrcB,
  output logic [3:0] output_ALUOp,
  output logic       output_PCSrc,
  output logic       output_keep_ALUOut,
  output logic       output_PCWrite,
  output logic       output_IRWrite,
  output logic       output_MemRead,
  output logic       output_MemWrite,
  output logic       output_RegWrite,
  output logic       output_IorD,
  output logic       output_MemtoReg,
  output logic       output_halted,
  output logic       output_illegal,
  output logic [3:0] output_state
);

  typedef enum logic [3:0] {
    S_RST       = 4'h0,
    S_FETCH     = 4'h1,
    S_DECODE    = 4'h2,
    S_EXEC_R    = 4'h3,
    S_EXEC_I    = 4'h4,
    S_ALU_WB    = 4'h5,
    S_MEM_ADDR  = 4'h6,
    S_MEM_READ  = 4'h7,
    S_MEM_WB    = 4'h8,
    S_MEM_WRITE = 4'h9,
    S_BRANCH    = 4'hA,
    S_JUMP      = 4'hB,
    S_HALT      = 4'hC
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_BLT   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_PASSA = 4'hF;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   branch_taken;

  // State register and sticky illegal flag; active-low reset returns to RST.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Branch condition from the flags the ALU produces for A-B this cycle.
  always_comb begin
    branch_taken = 1'b0;
    case (input_opcode)
      OP_BEQ:  branch_taken = input_Zero;
      OP_BNE:  branch_taken = ~input_Zero;
      OP_BLT:  branch_taken = input_negative;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state decode and Moore outputs (PCWrite/IRWrite are the gated exceptions).
  always_comb begin
    state_d            = state_q;
    illegal_d          = illegal_q;
    output_ALUSrcA     = 2'd0;
    output_ALUSrcB     = 2'd0;
    output_ALUOp       = ALU_ADD;
    output_PCSrc       = 1'b0;
    output_keep_ALUOut = 1'b1;
    output_PCWrite     = 1'b0;
    output_IRWrite     = 1'b0;
    output_MemRead     = 1'b0;
    output_MemWrite    = 1'b0;
    output_RegWrite    = 1'b0;
    output_IorD        = 1'b0;
    output_MemtoReg    = 1'b0;
    output_halted      = 1'b0;

    case (state_q)
      S_RST: begin
        // Everything, including the ALUOut hold, is low while in reset.
        output_keep_ALUOut = 1'b0;
        state_d            = S_FETCH;
      end
      S_FETCH: begin
        // PC+1 goes straight into the PC only on the cycle memory delivers.
        output_MemRead = 1'b1;
        output_ALUSrcB = 2'd1;
        output_PCWrite = input_mem_ready;
        output_IRWrite = input_mem_ready;
        state_d        = input_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALUOut captures PC+1+imm for a possible branch.
        output_ALUSrcB     = 2'd2;
        output_keep_ALUOut = 1'b0;
        case (input_opcode)
          OP_RTYPE:             state_d = S_EXEC_R;
          OP_ADDI:              state_d = S_EXEC_I;
          OP_LW, OP_SW:         state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLT: state_d = S_BRANCH;
          OP_JMP:               state_d = S_JUMP;
          OP_HALT:              state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        output_ALUSrcA     = 2'd2;
        output_ALUOp       = input_funct;
        output_keep_ALUOut = 1'b0;
        state_d            = S_ALU_WB;
      end
      S_EXEC_I: begin
        output_ALUSrcA     = 2'd2;
        output_ALUSrcB     = 2'd2;
        output_keep_ALUOut = 1'b0;
        state_d            = S_ALU_WB;
      end
      S_ALU_WB: begin
        output_RegWrite = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_ADDR: begin
        output_ALUSrcA     = 2'd2;
        output_ALUSrcB     = 2'd2;
        output_keep_ALUOut = 1'b0;
        state_d            = (input_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        output_IorD    = 1'b1;
        output_MemRead = 1'b1;
        state_d        = input_mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        output_RegWrite = 1'b1;
        output_MemtoReg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WRITE: begin
        output_IorD     = 1'b1;
        output_MemWrite = 1'b1;
        state_d         = input_mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_BRANCH: begin
        // Target stays in ALUOut while the ALU compares A and B.
        output_ALUSrcA = 2'd2;
        output_ALUOp   = ALU_SUB;
        output_PCSrc   = 1'b1;
        output_PCWrite = branch_taken;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        output_ALUSrcA = 2'd3;
        output_ALUOp   = ALU_PASSA;
        output_PCWrite = 1'b1;
        state_d        = S_FETCH;
      end
      S_HALT: begin
        output_halted = 1'b1;
        state_d       = S_HALT;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  assign output_illegal = illegal_q;
  assign output_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_control_fsm
//  Description : Directed self-checking bench for calc_control_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode, funct;
  logic       zero, neg, mem_ready;
  logic [1:0] src_a, src_b;
  logic [3:0] alu_op;
  logic       pc_src, keep, pc_write, ir_write, mem_read, mem_write;
  logic       reg_write, iord, mem_to_reg, halted, illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  calc_control_fsm dut (
    .clk                (clk),
    .reset              (reset),
    .input_opcode       (opcode),
    .input_funct        (funct),
    .input_Zero         (zero),
    .input_negative     (neg),
    .input_mem_ready    (mem_ready),
    .output_ALUSrcA     (src_a),
    .output_ALUSrcB     (src_b),
    .output_ALUOp       (alu_op),
    .output_PCSrc       (pc_src),
    .output_keep_ALUOut (keep),
    .output_PCWrite     (pc_write),
    .output_IRWrite     (ir_write),
    .output_MemRead     (mem_read),
    .output_MemWrite    (mem_write),
    .output_RegWrite    (reg_write),
    .output_IorD        (iord),
    .output_MemtoReg    (mem_to_reg),
    .output_halted      (halted),
    .output_illegal     (illegal),
    .output_state       (state)
  );

  always #5 clk = ~clk;

  // OR of every output bit, used to confirm the all-zero reset state.
  logic any_out;
  assign any_out = |{src_a, src_b, alu_op, pc_src, keep, pc_write, ir_write, mem_read,
                     mem_write, reg_write, iord, mem_to_reg, halted, illegal, state};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a 3-state branch starting in FETCH; expect the given PCWrite in BRANCH.
  task automatic run_branch(input string tag, input logic [3:0] op,
                            input logic z, input logic n, input logic exp_pcw);
    opcode = op; zero = z; neg = n; mem_ready = 1'b1;
    #1 check({tag, "_fetch"}, state, 4'h1);
    tick();
    check({tag, "_decode"}, state, 4'h2);
    tick();
    #1;
    check({tag, "_state"}, state, 4'hA);
    check({tag, "_pcwrite"}, pc_write, exp_pcw);
    check({tag, "_pcsrc"}, pc_src, 1'b1);
    check({tag, "_aluop"}, alu_op, 4'h1);
    check({tag, "_keep"}, keep, 1'b1);
    check({tag, "_srca"}, src_a, 2'd2);
    tick();
    check({tag, "_back_fetch"}, state, 4'h1);
  endtask

  logic [3:0] lw_states [10] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h6, 4'h7, 4'h7, 4'h7, 4'h7, 4'h8};
  logic       lw_ready  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int pcw_pulses;

  initial begin
    reset = 1'b0; opcode = 4'h0; funct = 4'h0; zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rst_state", state, 4'h0);
      check("rst_outputs", any_out, 1'b0);
    end
    reset = 1'b1;
    mem_ready = 1'b0;
    tick();
    #1;
    check("first_fetch", state, 4'h1);
    check("fetch_memread", mem_read, 1'b1);
    check("fetch_wait_pcwrite", pc_write, 1'b0);
    check("fetch_wait_irwrite", ir_write, 1'b0);
    tick();
    check("fetch_wait_hold", state, 4'h1);

    // R-type, funct 2.
    opcode = 4'h0; funct = 4'h2; mem_ready = 1'b1;
    #1 check("r_fetch_pcwrite", pc_write, 1'b1);
    check("r_fetch_irwrite", ir_write, 1'b1);
    check("r_fetch_srcb", src_b, 2'd1);
    tick();
    check("r_decode", state, 4'h2);
    check("r_decode_keep", keep, 1'b0);
    check("r_decode_srcb", src_b, 2'd2);
    tick();
    check("r_exec", state, 4'h3);
    check("r_exec_aluop", alu_op, 4'h2);
    check("r_exec_srca", src_a, 2'd2);
    check("r_exec_srcb", src_b, 2'd0);
    check("r_exec_keep", keep, 1'b0);
    tick();
    check("r_wb", state, 4'h5);
    check("r_wb_regwrite", reg_write, 1'b1);
    check("r_wb_memtoreg", mem_to_reg, 1'b0);
    tick();
    check("r_back_fetch", state, 4'h1);

    // LW with 2 fetch waits and 3 read waits: 10 cycles.
    opcode = 4'h2;
    pcw_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = lw_ready[i];
      #1;
      check($sformatf("lw_state_c%0d", i), state, lw_states[i]);
      if (pc_write) pcw_pulses++;
      if (i == 9) begin
        check("lw_wb_regwrite", reg_write, 1'b1);
        check("lw_wb_memtoreg", mem_to_reg, 1'b1);
      end
      if (i == 6) check("lw_read_iord", iord, 1'b1);
      tick();
    end
    check("lw_end_fetch", state, 4'h1);
    check("lw_pcwrite_pulses", pcw_pulses, 1);

    // SW, zero wait.
    opcode = 4'h3; mem_ready = 1'b1;
    tick(); tick();
    check("sw_memaddr", state, 4'h6);
    tick();
    check("sw_write", state, 4'h9);
    check("sw_memwrite", mem_write, 1'b1);
    check("sw_iord", iord, 1'b1);
    tick();
    check("sw_back_fetch", state, 4'h1);

    // Branches.
    run_branch("beq_z1", 4'h4, 1'b1, 1'b0, 1'b1);
    run_branch("bne_z1", 4'h5, 1'b1, 1'b0, 1'b0);
    run_branch("blt_n1", 4'h6, 1'b0, 1'b1, 1'b1);

    // JMP.
    opcode = 4'h7; mem_ready = 1'b1;
    tick(); tick();
    check("jmp_state", state, 4'hB);
    check("jmp_srca", src_a, 2'd3);
    check("jmp_aluop", alu_op, 4'hF);
    check("jmp_pcwrite", pc_write, 1'b1);
    check("jmp_pcsrc", pc_src, 1'b0);
    tick();
    check("jmp_back_fetch", state, 4'h1);

    // Illegal opcode A -> HALT, sticky until reset.
    opcode = 4'hA;
    tick();
    check("ill_decode", state, 4'h2);
    check("ill_not_yet", illegal, 1'b0);
    tick();
    check("ill_halt_state", state, 4'hC);
    check("ill_flag", illegal, 1'b1);
    check("ill_halted", halted, 1'b1);
    opcode = 4'h0;
    tick(); tick();
    check("ill_sticky_state", state, 4'hC);
    check("ill_sticky_flag", illegal, 1'b1);
    check("ill_halt_pcwrite", pc_write, 1'b0);
    reset = 1'b0;
    tick();
    check("ill_rst_state", state, 4'h0);
    check("ill_rst_flag", illegal, 1'b0);
    check("ill_rst_halted", halted, 1'b0);
    reset = 1'b1;
    tick();
    check("ill_refetch", state, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_control_fsm.md
# calc_control_fsm

Multi-cycle control state machine that drives the ALU/calculation datapath of the 16-bit processor. It decodes the fetched instruction opcode and produces every datapath select and enable: ALU source selects, ALU op, PC source, ALUOut hold, memory and register-file strobes. It consumes the ALU flags for branch resolution and a memory ready handshake for wait-stated fetch, load and store. It sits between the instruction register and the calculation datapath and is the sole sequencer of the core.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- input_opcode  in  4  instruction[15:12] from the instruction register.
- input_funct  in  4  instruction[3:0]; the ALU op for R-type.
- input_Zero, input_negative  in  1 each  ALU flags, combinational from the current cycle's ALU result.
- input_mem_ready  in  1  memory completes the current read or write this cycle.
- output_ALUSrcA  out  2  0=PC, 1=const 1, 2=A register, 3=immediate.
- output_ALUSrcB  out  2  0=B register, 1=const 1, 2=immediate.
- output_ALUOp  out  4  ADD=4'h0, SUB=4'h1, PASSA=4'hF; R-type passes input_funct.
- output_PCSrc  out  1  0=live ALU result, 1=ALUOut register.
- output_keep_ALUOut  out  1  1=ALUOut holds its value.
- output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite  out  1 each  enables.
- output_IorD  out  1  memory address: 0=PC, 1=ALUOut.
- output_MemtoReg  out  1  register write data: 0=ALUOut, 1=memory data.
- output_halted, output_illegal  out  1 each  status, sticky until reset.
- output_state  out  4  current state, for debug.

## Operation
- Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 BLT, 7 JMP, F HALT. Opcodes 8–E are illegal.
- Moore outputs decode from the state. The only exceptions are PCWrite and IRWrite, which are gated by input_mem_ready and the branch condition.
- Every signal not listed for a state is 0. ALU fields default to 0. keep_ALUOut defaults to 1.
- State encoding:
  - RST(0): all enables 0.
  - FETCH(1): IorD=0, MemRead=1, SrcA=0, SrcB=1, ADD, PCSrc=0. PCWrite = IRWrite = mem_ready.
  - DECODE(2): SrcA=0, SrcB=2, ADD, keep=0. This captures the branch target PC+1+imm.
  - EXEC_R(3): SrcA=2, SrcB=0, ALUOp=funct, keep=0.
  - EXEC_I(4) and MEM_ADDR(6): SrcA=2, SrcB=2, ADD, keep=0.
  - ALU_WB(5): RegWrite=1, MemtoReg=0.
  - MEM_READ(7): IorD=1, MemRead=1.
  - MEM_WB(8): RegWrite=1, MemtoReg=1.
  - MEM_WRITE(9): IorD=1, MemWrite=1.
  - BRANCH(A): SrcA=2, SrcB=0, SUB, keep=1, PCSrc=1. PCWrite=cond, where BEQ: Zero; BNE: !Zero; BLT: negative.
  - JUMP(B): SrcA=3, PASSA, PCSrc=0, PCWrite=1.
  - HALT(C): all enables 0, halted=1.
- Transitions:
  - RST→FETCH.
  - FETCH→FETCH while !mem_ready, else →DECODE.
  - DECODE→EXEC_R (op 0), EXEC_I (1), MEM_ADDR (2,3), BRANCH (4–6), JUMP (7), HALT (F).
  - DECODE→HALT on an illegal opcode, setting illegal=1.
  - EXEC_R, EXEC_I→ALU_WB.
  - MEM_ADDR→MEM_READ (LW) or MEM_WRITE (SW). The opcode is re-sampled here, and the IR holds it.
  - MEM_READ→MEM_READ until mem_ready, then →MEM_WB.
  - MEM_WRITE→MEM_WRITE until mem_ready, then →FETCH.
  - ALU_WB, MEM_WB, BRANCH, JUMP→FETCH.
  - HALT→HALT.

## Timing
- With zero wait states, cycles per instruction:
  - R-type, ADDI, SW: 4.
  - LW: 5.
  - BEQ, BNE, BLT, JMP: 3.
  - Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds 1.
- State register and the illegal flag update on the rising clk edge.
- Reset:
  - reset=0 at an edge forces RST and clears illegal, from any state, including mid-wait and HALT.
  - While in RST, every output is 0 and output_state=0.
  - The first FETCH is the cycle after reset is released.
- PC increments exactly once per fetch, on the mem_ready cycle only. PCWrite is never asserted during a fetch wait.
- In BRANCH, the ALUOut target is held (keep=1) while the ALU computes A−B. The flags are used in the same cycle.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.

## Test plan
- Reset: hold reset=0 for 3 cycles in any state, then release. Required: all outputs 0 and state=0 during reset, FETCH (state=1) one cycle after release, with MemRead=1 and PCWrite=0 until mem_ready.
- R-type op=0, funct=4'h2, mem_ready=1. Required: states 1,2,3,5,1. ALUOp=2, SrcA=2, SrcB=0, keep=0 in EXEC_R. RegWrite=1, MemtoReg=0 in ALU_WB.
- LW with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ. Required: 10 cycles total, PCWrite pulses exactly once, and MemtoReg=1 with RegWrite=1 in MEM_WB.
- BEQ with Zero=1, then BNE with Zero=1. Required: BEQ gives PCWrite=1 and PCSrc=1 in BRANCH; BNE gives PCWrite=0. Both return to FETCH after 3 cycles.
- Opcode 4'hA. Required: DECODE→HALT, with illegal=1 and halted=1 sticky. reset=0 clears both, and the next state is RST.
- JMP op=7. Required: SrcA=3, ALUOp=4'hF, PCWrite=1, PCSrc=0 in JUMP, then FETCH.
